mem_arbiter: RTL

- Shares the single-port 64K x 8 synchronous system memory between two requesters.
- Port A is the 6502 core. Port B is a DMA/program-loader master.
- Grants at most one access per cycle and drives the memory port.
- Returns read data with the memory's 1-cycle registered latency and holds it afterwards.
- Supports fixed-priority-with-starvation-guard or round-robin arbitration, plus bounded B burst locking.

---
 rtl/mem_arbiter.sv | 204 ++++++++++++++++++++
 1 files changed

// File: rtl/mem_arbiter.sv
// Two-port arbiter in front of a single-port synchronous 64K x 8 memory.
// Port A (CPU) and port B (DMA/loader) share the memory; read data returns one cycle after grant.
module mem_arbiter #(
   parameter int ADDR_W   = 16,
   parameter int DATA_W   = 8,
   parameter int RR_MODE  = 0,
   parameter int MAX_WAIT = 4,
   parameter int LOCK_MAX = 8
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic              a_req,
   input  logic              a_we,
   input  logic [ADDR_W-1:0] a_addr,
   input  logic [DATA_W-1:0] a_wdata,
   output logic              a_gnt,
   output logic              a_rvalid,
   output logic [DATA_W-1:0] a_rdata,
   input  logic              b_req,
   input  logic              b_we,
   input  logic [ADDR_W-1:0] b_addr,
   input  logic [DATA_W-1:0] b_wdata,
   input  logic              b_lock,
   output logic              b_gnt,
   output logic              b_rvalid,
   output logic [DATA_W-1:0] b_rdata,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_din,
   input  logic [DATA_W-1:0] mem_dout
);

   localparam logic       PORT_A     = 1'b0;
   localparam logic       PORT_B     = 1'b1;
   localparam logic [3:0] MAX_WAIT_C = 4'(MAX_WAIT);
   localparam logic [8:0] LOCK_MAX_C = 9'(LOCK_MAX);

   logic              a_gnt_s;
   logic              b_gnt_s;
   logic [3:0]        wait_b_r;
   logic              lock_r;
   logic [7:0]        lock_cnt_r;
   logic [8:0]        lock_inc_s;
   logic              last_r;
   logic              a_rvalid_r;
   logic              b_rvalid_r;
   logic [DATA_W-1:0] a_hold_r;
   logic [DATA_W-1:0] b_hold_r;

   assign lock_inc_s = {1'b0, lock_cnt_r} + 9'd1;

   // Grant selection: reset, B lock, single requester, then tie-break by mode
   always_comb begin
      a_gnt_s = 1'b0;
      b_gnt_s = 1'b0;
      if (RST) begin
         a_gnt_s = 1'b0;
         b_gnt_s = 1'b0;
      end else if (lock_r && b_req) begin
         b_gnt_s = 1'b1;
      end else if (a_req && !b_req) begin
         a_gnt_s = 1'b1;
      end else if (b_req && !a_req) begin
         b_gnt_s = 1'b1;
      end else if (a_req && b_req) begin
         if (RR_MODE != 0) begin
            if (last_r == PORT_A) begin
               b_gnt_s = 1'b1;
            end else begin
               a_gnt_s = 1'b1;
            end
         end else begin
            if (wait_b_r >= MAX_WAIT_C) begin
               b_gnt_s = 1'b1;
            end else begin
               a_gnt_s = 1'b1;
            end
         end
      end else begin
         a_gnt_s = 1'b0;
         b_gnt_s = 1'b0;
      end
   end

   assign a_gnt = a_gnt_s;
   assign b_gnt = b_gnt_s;

   // Memory port mux: granted port drives, otherwise all zero
   always_comb begin
      mem_we   = 1'b0;
      mem_addr = '0;
      mem_din  = '0;
      case ({a_gnt_s, b_gnt_s})
         2'b10: begin
            mem_we   = a_we;
            mem_addr = a_addr;
            mem_din  = a_wdata;
         end
         2'b01: begin
            mem_we   = b_we;
            mem_addr = b_addr;
            mem_din  = b_wdata;
         end
         default: begin
            mem_we   = 1'b0;
            mem_addr = '0;
            mem_din  = '0;
         end
      endcase
   end

   // Read return: live memory data in the valid cycle, held copy otherwise;
   // RST masks a return that lands in a reset cycle
   always_comb begin
      a_rvalid = 1'b0;
      b_rvalid = 1'b0;
      a_rdata  = '0;
      b_rdata  = '0;
      if (RST) begin
         a_rvalid = 1'b0;
         b_rvalid = 1'b0;
         a_rdata  = '0;
         b_rdata  = '0;
      end else begin
         a_rvalid = a_rvalid_r;
         b_rvalid = b_rvalid_r;
         if (a_rvalid_r) begin
            a_rdata = mem_dout;
         end else begin
            a_rdata = a_hold_r;
         end
         if (b_rvalid_r) begin
            b_rdata = mem_dout;
         end else begin
            b_rdata = b_hold_r;
         end
      end
   end

   // Read-valid pipeline and per-port data hold
   always_ff @(posedge CLK) begin
      if (RST) begin
         a_rvalid_r <= 1'b0;
         b_rvalid_r <= 1'b0;
         a_hold_r   <= '0;
         b_hold_r   <= '0;
      end else begin
         a_rvalid_r <= a_gnt_s && !a_we;
         b_rvalid_r <= b_gnt_s && !b_we;
         if (a_rvalid_r) begin
            a_hold_r <= mem_dout;
         end
         if (b_rvalid_r) begin
            b_hold_r <= mem_dout;
         end
      end
   end

   // Starvation counter for B and round-robin history
   always_ff @(posedge CLK) begin
      if (RST) begin
         wait_b_r <= 4'd0;
         last_r   <= PORT_B;
      end else begin
         if (b_req && !b_gnt_s) begin
            if (wait_b_r >= MAX_WAIT_C) begin
               wait_b_r <= MAX_WAIT_C;
            end else begin
               wait_b_r <= wait_b_r + 4'd1;
            end
         end else begin
            wait_b_r <= 4'd0;
         end
         if (a_gnt_s) begin
            last_r <= PORT_A;
         end else if (b_gnt_s) begin
            last_r <= PORT_B;
         end
      end
   end

   // Bounded B lock: the grant that reaches LOCK_MAX releases so A gets the next slot
   always_ff @(posedge CLK) begin
      if (RST) begin
         lock_r     <= 1'b0;
         lock_cnt_r <= 8'd0;
      end else if (!b_req) begin
         lock_r     <= 1'b0;
         lock_cnt_r <= 8'd0;
      end else if (b_gnt_s && b_lock) begin
         if (lock_inc_s < LOCK_MAX_C) begin
            lock_r     <= 1'b1;
            lock_cnt_r <= lock_inc_s[7:0];
         end else begin
            lock_r     <= 1'b0;
            lock_cnt_r <= 8'd0;
         end
      end else if (b_gnt_s) begin
         lock_r     <= 1'b0;
         lock_cnt_r <= 8'd0;
      end
   end

endmodule
